csr_access_seq: RTL and testbench

//  Upstream sequencer for the CSR register unit: accepts one SYSTEM/CSR instruction plus its rs1 value,

---
 rtl/csr_access_seq_pkg.sv | 40 ++++
 rtl/csr_access_seq_if.sv | 38 +++
 rtl/csr_access_seq_wdata_alu.sv | 47 ++++
 rtl/csr_access_seq.sv | 146 ++++++++++++++
 tb/tb_csr_access_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_access_seq_pkg.sv
// Shared types and constants for the CSR access sequencer.
//   state_t      : sequencer FSM states
//   csr_op_e     : SYSTEM funct3 encodings for the Zicsr ops
//   csr_decode_t : instr[31:7] viewed as CSR address / zimm / funct3 / rd
package csr_access_seq_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned ZIMM_W  = 5;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned RD_W    = 5;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [1:0] RO_BITS    = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [F3_W-1:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } csr_op_e;

  // Field order matches instr[31:7] so the slice can be cast directly.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ZIMM_W-1:0] zimm;
    logic [F3_W-1:0]   funct3;
    logic [RD_W-1:0]   rd;
  } csr_decode_t;

endpackage

// File: rtl/csr_access_seq_if.sv
// Bus bundle for the CSR access sequencer: issue handshake, CSR storage
// port and rd writeback handshake.
//   master : the sequencer (drives in_ready, csr_*, wb_* results)
//   slave  : issue stage / storage / writeback side
interface csr_access_seq_if #(
  parameter int unsigned N = 32
) ();
  import csr_access_seq_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  instr;
  logic [N-1:0]        rs1_val;

  logic [ADDR_W-1:0]   csr_addr;
  logic [N-1:0]        csr_rdata;
  logic                csr_legal;
  logic                csr_we;
  logic [N-1:0]        csr_wdata;

  logic                wb_valid;
  logic                wb_ready;
  logic [RD_W-1:0]     wb_rd;
  logic [N-1:0]        wb_data;
  logic                wb_illegal;

  modport master (
    input  in_valid, instr, rs1_val, csr_rdata, csr_legal, wb_ready,
    output in_ready, csr_addr, csr_we, csr_wdata,
           wb_valid, wb_rd, wb_data, wb_illegal
  );

  modport slave (
    output in_valid, instr, rs1_val, csr_rdata, csr_legal, wb_ready,
    input  in_ready, csr_addr, csr_we, csr_wdata,
           wb_valid, wb_rd, wb_data, wb_illegal
  );
endinterface

// File: rtl/csr_access_seq_wdata_alu.sv
// Combinational CSR write-data unit.
//   funct3_i      : op encoding
//   zimm_nz_i     : instr[19:15] != 0 (rs1 / uimm field)
//   old_i, src_i  : current CSR value and operand
//   wdata_c_o     : value to write
//   do_write_c_o  : op writes the CSR
//   op_ok_c_o     : funct3 is a defined CSR op
module csr_access_seq_wdata_alu
  import csr_access_seq_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [F3_W-1:0] funct3_i,
  input  logic            zimm_nz_i,
  input  logic [N-1:0]    old_i,
  input  logic [N-1:0]    src_i,
  output logic [N-1:0]    wdata_c_o,
  output logic            do_write_c_o,
  output logic            op_ok_c_o
);

  // Set/clear with a zero field are pure reads.
  always_comb begin
    wdata_c_o    = '0;
    do_write_c_o = 1'b0;
    op_ok_c_o    = 1'b0;
    case (funct3_i)
      CSRRW, CSRRWI: begin
        wdata_c_o    = src_i;
        do_write_c_o = 1'b1;
        op_ok_c_o    = 1'b1;
      end
      CSRRS, CSRRSI: begin
        wdata_c_o    = old_i | src_i;
        do_write_c_o = zimm_nz_i;
        op_ok_c_o    = 1'b1;
      end
      CSRRC, CSRRCI: begin
        wdata_c_o    = old_i & ~src_i;
        do_write_c_o = zimm_nz_i;
        op_ok_c_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_seq.sv
// CSR access sequencer: takes one SYSTEM/CSR op, reads the old CSR value,
// issues the write, then returns the old value for rd writeback.
//   clk, rstn : clock, async active-low reset
//   bus       : csr_access_seq_if.master (issue, CSR storage, writeback)
module csr_access_seq
  import csr_access_seq_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic              clk,
  input  logic              rstn,
  csr_access_seq_if.master  bus
);

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  csr_decode_t dec_q, dec_d;
  logic [N-1:0] rs1_q, rs1_d;
  logic [N-1:0] old_q, old_d;
  logic        ill_q, ill_d;
  logic        csr_we_q, csr_we_d;
  logic [N-1:0] csr_wdata_q, csr_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [N-1:0] wb_data_q, wb_data_d;
  logic        wb_ill_q, wb_ill_d;

  logic [N-1:0] src_c;
  logic [N-1:0] alu_wdata_c;
  logic        alu_do_write_c;
  logic        alu_op_ok_c;
  logic        illegal_c;
  logic        unused_opc;

  // Opcode is routed by the issue stage and not checked here.
  assign unused_opc = ^bus.instr[6:0];

  assign src_c = dec_q.funct3[2] ? N'(dec_q.zimm) : rs1_q;

  // Write data from live storage read data during READ.
  csr_access_seq_wdata_alu #(.N(N)) u_alu (
    .funct3_i     (dec_q.funct3),
    .zimm_nz_i    (|dec_q.zimm),
    .old_i        (bus.csr_rdata),
    .src_i        (src_c),
    .wdata_c_o    (alu_wdata_c),
    .do_write_c_o (alu_do_write_c),
    .op_ok_c_o    (alu_op_ok_c)
  );

  // Writing a read-only CSR is illegal; reading it is fine.
  assign illegal_c = ~alu_op_ok_c | ~bus.csr_legal |
                     (alu_do_write_c & (dec_q.addr[11:10] == RO_BITS));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and register updates.
  always_comb begin
    state_d     = state_q;
    dec_d       = dec_q;
    rs1_d       = rs1_q;
    old_d       = old_q;
    ill_d       = ill_q;
    csr_we_d    = 1'b0;
    csr_wdata_d = csr_wdata_q;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_ill_d    = wb_ill_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          dec_d   = csr_decode_t'(bus.instr[31:7]);
          rs1_d   = bus.rs1_val;
          state_d = READ;
        end
      end
      READ: begin
        old_d       = bus.csr_rdata;
        ill_d       = illegal_c;
        csr_we_d    = alu_do_write_c & ~illegal_c;
        csr_wdata_d = alu_wdata_c;
        state_d     = WRITE;
      end
      WRITE: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = dec_q.rd;
        wb_data_d  = ill_q ? '0 : old_q;
        wb_ill_d   = ill_q;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.wb_ready) begin
          wb_valid_d = 1'b0;
          wb_ill_d   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_ready_q  <= 1'b0;
      dec_q       <= '0;
      rs1_q       <= '0;
      old_q       <= '0;
      ill_q       <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_ill_q    <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      dec_q       <= dec_d;
      rs1_q       <= rs1_d;
      old_q       <= old_d;
      ill_q       <= ill_d;
      csr_we_q    <= csr_we_d;
      csr_wdata_q <= csr_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_ill_q    <= wb_ill_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.csr_addr   = dec_q.addr;
  assign bus.csr_we     = csr_we_q;
  assign bus.csr_wdata  = csr_wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_illegal = wb_ill_q;

endmodule

// File: tb/tb_csr_access_seq.sv
// Testbench for csr_access_seq: CSR storage model, directed and random ops
// checked against a spec-level reference model.
module tb_csr_access_seq;
  import csr_access_seq_pkg::*;

  localparam int unsigned N = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  csr_access_seq_if #(.N(N)) bus ();
  csr_access_seq #(.N(N)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  // CSR storage model: combinational read, counts committed writes.
  logic [N-1:0] mem [4096];
  bit           legal_mem [4096];
  int           wr_cnt = 0;
  assign bus.csr_rdata = mem[bus.csr_addr];
  assign bus.csr_legal = legal_mem[bus.csr_addr];
  always @(posedge clk) if (bus.csr_we === 1'b1) wr_cnt <= wr_cnt + 1;

  int cmp = 0;
  int bad = 0;

  typedef struct {
    logic [31:0]  ins;
    logic [N-1:0] rs1;
    logic [N-1:0] old;
    bit           legal;
    int           stall;
  } op_t;

  typedef struct {
    bit           we;
    logic [N-1:0] wdata;
    bit           ill;
    logic [N-1:0] data;
    logic [4:0]   rd;
  } exp_t;

  typedef struct {
    bit           timeout;
    int           wait_n;
    int           we_cnt;
    int           we_cyc;
    logic [N-1:0] wdata;
    logic [11:0]  addr_rd;
    int           wbv_cyc;
    logic [4:0]   rd;
    logic [N-1:0] data;
    logic         ill;
    bit           stable;
    bit           busy_rdy;
    int           rdy_cyc;
    int           commits;
  } obs_t;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [11:0] addr,
                                     input logic [4:0] rs1f, input logic [4:0] rd);
    return {addr, rs1f, f3, rd, OPC_SYSTEM};
  endfunction

  // Reference: Zicsr semantics from the instruction fields.
  function automatic exp_t model(input op_t op);
    exp_t         e;
    logic [2:0]   f3;
    logic [4:0]   z;
    logic [N-1:0] src;
    bit           kind_ok;
    bit           wr;
    f3 = op.ins[14:12];
    z  = op.ins[19:15];
    src = f3[2] ? {{(N-5){1'b0}}, z} : op.rs1;
    case (f3[1:0])
      2'd1:    e.wdata = src;
      2'd2:    e.wdata = op.old | src;
      2'd3:    e.wdata = op.old & ~src;
      default: e.wdata = '0;
    endcase
    kind_ok = (f3[1:0] != 2'd0);
    wr      = kind_ok && ((f3[1:0] == 2'd1) || (z != 5'd0));
    e.ill   = !kind_ok || !op.legal || (wr && (op.ins[31:30] == 2'b11));
    e.we    = wr && !e.ill;
    e.data  = e.ill ? '0 : op.old;
    e.rd    = op.ins[11:7];
    return e;
  endfunction

  // Drive one op and record what the DUT did, cycle by cycle after acceptance.
  task automatic run_op(input op_t op, output obs_t o);
    int n;
    int cyc;
    int rem;
    int wc0;
    bit hs;
    o.timeout = 0; o.wait_n = 0; o.we_cnt = 0; o.we_cyc = -1; o.wdata = '0;
    o.addr_rd = '0; o.wbv_cyc = -1; o.rd = '0; o.data = '0; o.ill = 1'b0;
    o.stable = 1; o.busy_rdy = 0; o.rdy_cyc = -1; o.commits = 0;
    mem[op.ins[31:20]]       = op.old;
    legal_mem[op.ins[31:20]] = op.legal;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    o.wait_n = n;
    if (bus.in_ready !== 1'b1) begin o.timeout = 1; return; end
    wc0 = wr_cnt;
    bus.instr = op.ins; bus.rs1_val = op.rs1; bus.in_valid = 1'b1; bus.wb_ready = 1'b0;
    cyc = 0; hs = 0; rem = op.stall;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (hs) begin
        o.rdy_cyc = (bus.in_ready === 1'b1 && bus.wb_valid === 1'b0) ? cyc : -2;
        break;
      end
      if (bus.in_ready !== 1'b0) o.busy_rdy = 1;
      if (cyc == 1) o.addr_rd = bus.csr_addr;
      if (bus.csr_we === 1'b1) begin
        o.we_cnt++; o.we_cyc = cyc; o.wdata = bus.csr_wdata;
      end
      if (bus.wb_valid === 1'b1) begin
        if (o.wbv_cyc < 0) begin
          o.wbv_cyc = cyc; o.rd = bus.wb_rd; o.data = bus.wb_data; o.ill = bus.wb_illegal;
        end else if (bus.wb_rd !== o.rd || bus.wb_data !== o.data || bus.wb_illegal !== o.ill) begin
          o.stable = 0;
        end
        if (rem == 0) begin bus.wb_ready = 1'b1; hs = 1; end
        else rem--;
      end
      // Junk requests while busy must be ignored.
      if (cyc <= 2) begin bus.in_valid = 1'b1; bus.instr = $urandom; bus.rs1_val = $urandom; end
      else bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0; bus.wb_ready = 1'b0;
    if (o.rdy_cyc == -1) o.timeout = 1;
    o.commits = wr_cnt - wc0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.wb_ready = 1'b0; bus.instr = '0; bus.rs1_val = '0;
    for (int i = 0; i < 4096; i++) begin mem[i] = $urandom; legal_mem[i] = 1'b1; end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    cmp++; if ({bus.csr_we, bus.wb_valid, bus.wb_illegal} !== 3'b000) begin bad++;
      $display("FAIL reset_strobes got %b want 000", {bus.csr_we, bus.wb_valid, bus.wb_illegal}); end
    cmp++; if (bus.csr_addr !== 12'h0 || bus.wb_rd !== 5'd0) begin bad++;
      $display("FAIL reset_addr_rd got %h/%h want 0/0", bus.csr_addr, bus.wb_rd); end
    cmp++; if (bus.csr_wdata !== '0 || bus.wb_data !== '0) begin bad++;
      $display("FAIL reset_data got %h/%h want 0/0", bus.csr_wdata, bus.wb_data); end
    rstn = 1'b1;
    @(negedge clk);
    cmp++; if (bus.in_ready !== 1'b1) begin bad++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    op_t  tbl [12];
    obs_t o;
    exp_t e;
    tbl[0]  = '{mk(3'b001, 12'h340, 5'd1, 5'd5),  32'hDEAD_BEEF, 32'h1234, 1, 0};
    tbl[1]  = '{mk(3'b010, 12'h300, 5'd0, 5'd3),  32'hFFFF_FFFF, 32'h88,   1, 0};
    tbl[2]  = '{mk(3'b110, 12'h300, 5'd5, 5'd3),  32'h0,         32'h88,   1, 0};
    tbl[3]  = '{mk(3'b011, 12'h305, 5'd2, 5'd7),  32'h0F,        32'hFF,   1, 0};
    tbl[4]  = '{mk(3'b111, 12'h305, 5'd1, 5'd7),  32'h0,         32'h3,    1, 0};
    tbl[5]  = '{mk(3'b001, 12'hC00, 5'd4, 5'd9),  32'h5555,      32'hAAAA, 1, 0};
    tbl[6]  = '{mk(3'b010, 12'hC00, 5'd0, 5'd9),  32'h5555,      32'hC0C0, 1, 0};
    tbl[7]  = '{mk(3'b100, 12'h340, 5'd1, 5'd10), 32'h77,        32'h99,   1, 0};
    tbl[8]  = '{mk(3'b001, 12'h340, 5'd1, 5'd10), 32'h77,        32'h99,   0, 0};
    tbl[9]  = '{mk(3'b010, 12'h341, 5'd3, 5'd11), 32'h10,        32'h1,    1, 0};
    tbl[10] = '{mk(3'b001, 12'h342, 5'd2, 5'd12), 32'hCAFE,      32'hF00D, 1, 5};
    tbl[11] = '{mk(3'b011, 12'h343, 5'd6, 5'd0),  32'hF0,        32'hFF,   1, 1};
    foreach (tbl[i]) begin
      e = model(tbl[i]);
      run_op(tbl[i], o);
      cmp++; if (o.timeout) begin bad++; $display("FAIL dir%0d timeout got 1 want 0", i); end
      cmp++; if (o.addr_rd !== tbl[i].ins[31:20]) begin bad++;
        $display("FAIL dir%0d csr_addr got %h want %h", i, o.addr_rd, tbl[i].ins[31:20]); end
      cmp++; if (o.we_cnt != int'(e.we) || o.commits != int'(e.we)) begin bad++;
        $display("FAIL dir%0d we_count got %0d/%0d want %0d", i, o.we_cnt, o.commits, e.we); end
      if (e.we) begin
        cmp++; if (o.we_cyc != 2 || o.wdata !== e.wdata) begin bad++;
          $display("FAIL dir%0d wdata got %h@%0d want %h@2", i, o.wdata, o.we_cyc, e.wdata); end
      end
      cmp++; if (o.wbv_cyc != 3) begin bad++; $display("FAIL dir%0d wb_cycle got %0d want 3", i, o.wbv_cyc); end
      cmp++; if (o.rd !== e.rd || o.data !== e.data || o.ill !== e.ill) begin bad++;
        $display("FAIL dir%0d wb got rd=%0d data=%h ill=%b want rd=%0d data=%h ill=%b",
                 i, o.rd, o.data, o.ill, e.rd, e.data, e.ill); end
      cmp++; if (!o.stable || o.busy_rdy || o.rdy_cyc != 4 + tbl[i].stall) begin bad++;
        $display("FAIL dir%0d hold got stable=%0d busy_rdy=%0d ready_at=%0d want 1/0/%0d",
                 i, o.stable, o.busy_rdy, o.rdy_cyc, 4 + tbl[i].stall); end
    end
  endtask

  task automatic test_back_to_back();
    op_t  op;
    obs_t o;
    for (int i = 0; i < 4; i++) begin
      op = '{mk(3'b001, 12'h180 + 12'(i), 5'(i + 1), 5'(i + 1)), $urandom, $urandom, 1, 0};
      run_op(op, o);
      if (i > 0) begin
        cmp++; if (o.wait_n != 0) begin bad++; $display("FAIL b2b%0d accept_wait got %0d want 0", i, o.wait_n); end
      end
      cmp++; if (o.rdy_cyc != 4 || o.we_cyc != 2 || o.data !== op.old) begin bad++;
        $display("FAIL b2b%0d got ready_at=%0d we_at=%0d data=%h want 4/2/%h", i, o.rdy_cyc, o.we_cyc, o.data, op.old); end
    end
  endtask

  task automatic test_random();
    op_t  op;
    obs_t o;
    exp_t e;
    logic [11:0] addr;
    logic [4:0]  rs1f;
    for (int i = 0; i < 40; i++) begin
      addr = 12'($urandom);
      if ($urandom_range(0, 3) == 0) addr[11:10] = 2'b11;
      rs1f = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      op.ins   = mk(3'($urandom_range(0, 7)), addr, rs1f, 5'($urandom));
      op.rs1   = $urandom;
      op.old   = $urandom;
      op.legal = ($urandom_range(0, 7) != 0);
      op.stall = $urandom_range(0, 3);
      e = model(op);
      run_op(op, o);
      cmp++; if (o.timeout || o.addr_rd !== addr) begin bad++;
        $display("FAIL rnd%0d addr/timeout got %h/%0d want %h/0", i, o.addr_rd, o.timeout, addr); end
      cmp++; if (o.we_cnt != int'(e.we) || o.commits != int'(e.we)) begin bad++;
        $display("FAIL rnd%0d we_count got %0d/%0d want %0d", i, o.we_cnt, o.commits, e.we); end
      if (e.we) begin
        cmp++; if (o.we_cyc != 2 || o.wdata !== e.wdata) begin bad++;
          $display("FAIL rnd%0d wdata got %h@%0d want %h@2", i, o.wdata, o.we_cyc, e.wdata); end
      end
      cmp++; if (o.wbv_cyc != 3 || o.rd !== e.rd || o.data !== e.data || o.ill !== e.ill) begin bad++;
        $display("FAIL rnd%0d wb got @%0d rd=%0d data=%h ill=%b want @3 rd=%0d data=%h ill=%b",
                 i, o.wbv_cyc, o.rd, o.data, o.ill, e.rd, e.data, e.ill); end
      cmp++; if (!o.stable || o.busy_rdy || o.rdy_cyc != 4 + op.stall) begin bad++;
        $display("FAIL rnd%0d hold got stable=%0d busy_rdy=%0d ready_at=%0d want 1/0/%0d",
                 i, o.stable, o.busy_rdy, o.rdy_cyc, 4 + op.stall); end
    end
  endtask

  task automatic test_reset_in_write();
    op_t  op;
    obs_t o;
    int   wc0;
    mem[12'h341] = 32'h0000_00AA; legal_mem[12'h341] = 1'b1;
    @(negedge clk);
    cmp++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstw_idle in_ready got %b want 1", bus.in_ready); end
    wc0 = wr_cnt;
    bus.instr = mk(3'b001, 12'h341, 5'd1, 5'd4); bus.rs1_val = 32'h1111; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    cmp++; if (bus.csr_we !== 1'b1) begin bad++; $display("FAIL rstw_in_write csr_we got %b want 1", bus.csr_we); end
    #1 rstn = 1'b0;
    #1;
    cmp++; if ({bus.in_ready, bus.csr_we, bus.wb_valid, bus.wb_illegal, bus.csr_addr, bus.csr_wdata,
                bus.wb_rd, bus.wb_data} !== '0) begin bad++;
      $display("FAIL rstw_outputs got we=%b wbv=%b addr=%h wdata=%h data=%h want all 0",
               bus.csr_we, bus.wb_valid, bus.csr_addr, bus.csr_wdata, bus.wb_data); end
    @(negedge clk);
    @(negedge clk);
    cmp++; if (wr_cnt != wc0) begin bad++; $display("FAIL rstw_commit got %0d writes want 0", wr_cnt - wc0); end
    rstn = 1'b1;
    @(negedge clk);
    cmp++; if (bus.in_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin bad++;
      $display("FAIL rstw_idle_after got ready=%b wbv=%b want 1/0", bus.in_ready, bus.wb_valid); end
    op = '{mk(3'b010, 12'h341, 5'd2, 5'd6), 32'h0100, 32'h00AA, 1, 0};
    run_op(op, o);
    cmp++; if (o.we_cnt != 1 || o.wdata !== 32'h01AA || o.data !== 32'h00AA || o.ill !== 1'b0) begin bad++;
      $display("FAIL rstw_next_op got we=%0d wdata=%h data=%h ill=%b want 1/000001aa/000000aa/0",
               o.we_cnt, o.wdata, o.data, o.ill); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_in_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
